// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the IO register offsets within the memory-mapped IO window.
package dmem_pkg;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  localparam logic [31:0] IO_DATA   = 32'd0;
  localparam logic [31:0] IO_STATUS = 32'd4;
  localparam logic [31:0] IO_SPAN   = 32'd8;

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO feeding the IO sink. A push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module io_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word RAM plus an 8-byte IO window
// (byte output FIFO and status register), one-cycle registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 256,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        io_valid,
  input  logic        io_ready,
  output logic [7:0]  io_data
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

  logic [31:0]   ram [MEM_WORDS];
  state_t        state;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic [31:0]   io_off;
  logic          ram_hit;
  logic          io_hit;
  logic          req_err;
  logic          io_data_store;
  logic          accept;
  logic          pop;
  logic [AW-1:0] ram_idx;
  logic [31:0]   load_data;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  always_comb begin
    io_off        = req_addr - IO_BASE;
    ram_hit       = ({1'b0, req_addr} < RAM_BYTES);
    io_hit        = !ram_hit && (io_off < IO_SPAN);
    req_err       = (req_addr[1:0] != 2'b00) || (!ram_hit && !io_hit);
    ram_idx       = req_addr[AW+1:2];
    io_data_store = req_we && io_hit && !req_err && (io_off == IO_DATA);
    pop           = io_valid && io_ready;
    // Outputs are masked while reset is high so a pending response never shows.
    req_ready     = !reset && (state == IDLE) && !(io_data_store && fifo_full && !pop);
    accept        = req_valid && req_ready;

    load_data = '0;
    if (!req_err && !req_we) begin
      if (ram_hit)                   load_data = ram[ram_idx];
      else if (io_off == IO_STATUS)  load_data = {30'b0, fifo_full, fifo_empty};
    end

    rsp_valid = rsp_valid_q && !reset;
    rsp_rdata = rsp_valid ? rsp_rdata_q : '0;
    rsp_err   = rsp_valid ? rsp_err_q : 1'b0;
    io_valid  = !fifo_empty && !reset;
    io_data   = io_valid ? fifo_head : '0;
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && ram_hit && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_be[b]) ram[ram_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data;
            rsp_err_q   <= req_err;
          end
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  io_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && io_data_store),
    .push_data (req_wdata[7:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single requests plus
// hand-written FIFO back-pressure and reset-during-response sequences.
module tb_dmem_responder;

  localparam logic [31:0] IOB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        io_valid;
  logic        io_ready;
  logic [7:0]  io_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_WORDS  (256),
    .IO_BASE    (IOB),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .io_valid  (io_valid),
    .io_ready  (io_ready),
    .io_data   (io_data)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the response.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    bit acc = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    #1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready) acc = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: req_ready never asserted", name);
    end else begin
      chk({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({name, "_rdata"}, rsp_rdata, exp_rdata);
      chk({name, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      @(posedge clk); #1;
      chk({name, "_idle_valid"}, {31'b0, rsp_valid}, 32'd0);
      chk({name, "_idle_rdata"}, rsp_rdata, 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    io_ready  = 1'b0;

    vecs.push_back('{"st_full",    1'b1, 32'h10,      32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{"ld_full",    1'b0, 32'h10,      32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{"st_byte0",   1'b1, 32'h10,      32'h000000AA, 4'h1, 32'h0,        1'b0});
    vecs.push_back('{"ld_byte0",   1'b0, 32'h10,      32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{"ld_misal",   1'b0, 32'h12,      32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{"ld_hole",    1'b0, 32'h4000,    32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{"st_misal",   1'b1, 32'h11,      32'h12345678, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{"st_hole",    1'b1, 32'h400,     32'h12345678, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{"ld_keep",    1'b0, 32'h10,      32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{"st_top",     1'b1, 32'h3FC,     32'h11223344, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{"st_top_hi",  1'b1, 32'h3FC,     32'hAABBCCDD, 4'hC, 32'h0,        1'b0});
    vecs.push_back('{"ld_top",     1'b0, 32'h3FC,     32'h0,        4'h0, 32'hAABB3344, 1'b0});
    vecs.push_back('{"ld_stat_e",  1'b0, IOB + 32'd4, 32'h0,        4'h0, 32'h1,        1'b0});
    vecs.push_back('{"st_stat",    1'b1, IOB + 32'd4, 32'h000000FF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{"ld_iodata",  1'b0, IOB,         32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{"ld_io_past", 1'b0, IOB + 32'd8, 32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{"ld_io_mis",  1'b0, IOB + 32'd2, 32'h0,        4'h0, 32'h0,        1'b1});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_io_valid",  {31'b0, io_valid}, 32'd0);
    chk("rst_io_data",   {24'b0, io_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i])
      do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err);
    chk("no_stray_push", {31'b0, io_valid}, 32'd0);

    // Fill the FIFO with the sink stalled, then observe back-pressure.
    for (int i = 0; i < 4; i++)
      do_req($sformatf("push%0d", i), 1'b1, IOB, 32'h41 + i, 4'hF, 32'h0, 1'b0);
    chk("full_io_valid", {31'b0, io_valid}, 32'd1);
    chk("full_io_head",  {24'b0, io_data}, 32'h41);
    req_valid = 1'b1; req_we = 1'b1; req_addr = IOB; req_wdata = 32'h45; req_be = 4'hF;
    #1;
    chk("stall_ready0", {31'b0, req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_ready1", {31'b0, req_ready}, 32'd0);
    chk("stall_no_rsp", {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    do_req("ld_stat_full", 1'b0, IOB + 32'd4, 32'h0, 4'h0, 32'h2, 1'b0);

    // Push while full with a simultaneous pop must be accepted.
    req_valid = 1'b1; req_we = 1'b1; req_addr = IOB; req_wdata = 32'h45; req_be = 4'hF;
    io_ready  = 1'b1;
    #1;
    chk("full_pop_ready", {31'b0, req_ready}, 32'd1);
    chk("drain_41", {24'b0, io_data}, 32'h41);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("push5_rsp", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0h", 8'h42 + i), {23'b0, io_valid, io_data}, {23'b0, 1'b1, 8'h42 + 8'(i)});
      @(posedge clk); #1;
    end
    chk("drained", {31'b0, io_valid}, 32'd0);
    io_ready = 1'b0;
    do_req("ld_stat_empty", 1'b0, IOB + 32'd4, 32'h0, 4'h0, 32'h1, 1'b0);

    // Reset while a load response is pending drops it and empties the FIFO.
    do_req("push_pre_rst", 1'b1, IOB, 32'h55, 4'hF, 32'h0, 1'b0);
    chk("pre_rst_io", {31'b0, io_valid}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    #1;
    chk("rst_ld_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    reset = 1'b1;
    #1;
    req_valid = 1'b0;
    chk("rst_resp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'd0);
    chk("rst_resp_io", {31'b0, io_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_valid2", {31'b0, rsp_valid}, 32'd0);
    do_req("ld_stat_rst", 1'b0, IOB + 32'd4, 32'h0, 4'h0, 32'h1, 1'b0);
    do_req("ld_ram_kept", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter IO_BASE, default 32'hFFFF_0000, meaning base of the 8-byte memory-mapped IO window.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning IO output byte FIFO depth (power of two).
REQ-004 SHALL have ports:
- clk  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  core presents a data request
- req_ready  output  1  responder accepts the request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load data
- rsp_err  output  1  request rejected
- io_valid  output  1  IO FIFO head byte available
- io_ready  input  1  IO sink consumes head byte
- io_data  output  8  IO FIFO head byte

Function
REQ-005 SHALL implement FSM states IDLE and RESP; a request is accepted on a cycle with req_valid && req_ready.
REQ-006 SHALL drive req_ready = 1 only in IDLE, except 0 when the request is an IO_DATA store and the FIFO is full.
REQ-007 SHALL move IDLE->RESP on accept; RESP->IDLE unconditionally next cycle; one outstanding request maximum.
REQ-008 SHALL assert rsp_valid for exactly the RESP cycle, so response latency is one cycle after accept.
REQ-009 SHALL drive rsp_rdata and rsp_err to 0 whenever rsp_valid = 0.
REQ-010 SHALL, for RAM loads (addr < 4*MEM_WORDS), return the word at addr[.. :2] registered at accept.
REQ-011 SHALL, for RAM stores, write only the bytes with req_be set, at the accept edge; the response carries rdata = 0.
REQ-012 SHALL treat IO_BASE+0 (IO_DATA) stores as a push of req_wdata[7:0] into the FIFO; loads there return 0.
REQ-013 SHALL return {30'b0, fifo_full, fifo_empty} on loads of IO_BASE+4 (IO_STATUS) and ignore stores there.
REQ-014 SHALL flag rsp_err = 1 with no side effects when addr[1:0] != 0 or addr lies outside RAM and outside the IO window.
REQ-015 SHALL have io_valid = !fifo_empty and io_data = head byte; a pop occurs on io_valid && io_ready.
REQ-016 SHALL allow push and pop in the same cycle when full: the pop frees the slot and the push is accepted (req_ready = 1).
REQ-017 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and track occupancy 0..FIFO_DEPTH.
REQ-018 SHALL, on a RAM load in RESP that reads the address written in the previous cycle, return the newly written data.

Reset
REQ-019 SHALL, while reset = 1, force state IDLE, FIFO empty, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, io_valid = 0, io_data = 0.
REQ-020 SHALL, when reset occurs while in RESP, drop the pending response without emitting it.
REQ-021 SHALL NOT clear RAM contents on reset.

Structure
REQ-022 SHALL place the IO register offsets (IO_DATA = 0, IO_STATUS = 4) and the FSM state enum in a shared package, dmem_pkg.
REQ-023 SHALL implement the IO byte FIFO as one sub-module, io_byte_fifo.

Verification
REQ-024 Store 0xDEADBEEF at 0x10 with be = 4'b1111, then load 0x10 -> rsp_valid one cycle after each accept; rdata = 0xDEADBEEF.
REQ-025 Store 0x000000AA at 0x10 with be = 4'b0001 over 0xDEADBEEF, then load -> rdata = 0xDEADBEAA.
REQ-026 Load at 0x12 and at 0x0000_4000 -> rsp_err = 1, rdata = 0; RAM unchanged.
REQ-027 Five IO_DATA stores of 0x41..0x45 with io_ready = 0 -> fifth store stalls (req_ready = 0); IO_STATUS load returns 0x2; raising io_ready drains 0x41..0x44, then the fifth push completes.
REQ-028 Assert reset during RESP after a load -> no rsp_valid; IO_STATUS returns 0x1 afterwards.
